// File: rtl/pipe_adder_n.sv
// Pipelined ripple-slice adder/subtractor with valid/ready flow control.
// Optional macro PIPE_ADDER_SAT_EN saturates the sum on signed overflow.
module pipe_adder_n #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    generate
        if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $fatal(1, "pipe_adder_n: illegal WIDTH/STAGES combination");
        end
    endgenerate

    localparam int unsigned W = WIDTH / STAGES;

    // Per-stage state: valid, carry out of the slice just added, and skew copies
    // of the operands (y already inverted for subtract) plus the partial sum.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  xs_q [STAGES];
    logic [WIDTH-1:0]  xs_d [STAGES];
    logic [WIDTH-1:0]  ys_q [STAGES];
    logic [WIDTH-1:0]  ys_d [STAGES];
    logic [WIDTH-1:0]  ss_q [STAGES];
    logic [WIDTH-1:0]  ss_d [STAGES];
    logic              ovf_q, ovf_d;

    logic              stall;
    logic [WIDTH-1:0]  xi, yi, si;
    logic              ci;
    logic [W:0]        slice;
    logic              msb_cin;

    assign stall    = vld_q[STAGES-1] && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        vld_d   = '0;
        c_d     = '0;
        xs_d    = '{default: '0};
        ys_d    = '{default: '0};
        ss_d    = '{default: '0};
        xi      = '0;
        yi      = '0;
        si      = '0;
        ci      = 1'b0;
        slice   = '0;
        msb_cin = 1'b0;
        ovf_d   = 1'b0;

        for (int k = 0; k < int'(STAGES); k++) begin
            if (k == 0) begin
                xi       = x;
                yi       = sub ? ~y : y;
                ci       = sub ? ~cin : cin;
                si       = '0;
                vld_d[k] = in_valid;
            end else begin
                xi       = xs_q[(k == 0) ? 0 : k - 1];
                yi       = ys_q[(k == 0) ? 0 : k - 1];
                ci       = c_q[(k == 0) ? 0 : k - 1];
                si       = ss_q[(k == 0) ? 0 : k - 1];
                vld_d[k] = vld_q[(k == 0) ? 0 : k - 1];
            end
            slice            = {1'b0, xi[k*W +: W]} + {1'b0, yi[k*W +: W]} + {{W{1'b0}}, ci};
            si[k*W +: W]     = slice[W-1:0];
            xs_d[k]          = xi;
            ys_d[k]          = yi;
            ss_d[k]          = si;
            c_d[k]           = slice[W];
        end

        // The loop leaves the final stage's operands in xi/yi/si; carry into the
        // MSB is recovered from the sum bit rather than a separate narrow add.
        msb_cin = xi[WIDTH-1] ^ yi[WIDTH-1] ^ si[WIDTH-1];
        ovf_d   = msb_cin ^ c_d[STAGES-1];

`ifdef PIPE_ADDER_SAT_EN
        if (ovf_d) begin
            ss_d[STAGES-1] = xi[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            xs_q  <= '{default: '0};
            ys_q  <= '{default: '0};
            ss_q  <= '{default: '0};
            ovf_q <= 1'b0;
        end else if (!stall) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            xs_q  <= xs_d;
            ys_q  <= ys_d;
            ss_q  <= ss_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = ss_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder_n.sv
// Directed and randomised checks for pipe_adder_n at WIDTH=16, STAGES=2.
module tb_pipe_adder_n;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_adder_n #(.WIDTH(16), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {ovf, cout, sum}, overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic s);
        logic [15:0] be;
        logic        ce;
        logic [16:0] full;
        logic [15:0] r;
        logic        o;
        be   = s ? ~b : b;
        ce   = s ? ~c : c;
        full = {1'b0, a} + {1'b0, be} + {16'd0, ce};
        r    = full[15:0];
        o    = (a[15] == be[15]) && (r[15] != a[15]);
`ifdef PIPE_ADDER_SAT_EN
        if (o) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {o, full[16], r};
    endfunction

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s);
        in_valid = v;
        x        = a;
        y        = b;
        cin      = c;
        sub      = s;
    endtask

    task automatic test_reset;
        rst_n     = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({ovf, cout, sum} !== 18'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {ovf, cout, sum});
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || {ovf, cout, sum} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got valid=%b data=%h expected 0/0", out_valid,
                     {ovf, cout, sum});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_add_carry;
        @(negedge clk);
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL carry_accept: in_ready got %b expected 1", in_ready);
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL carry_lat1: out_valid got %b expected 0", out_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b0, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL carry_result: got v=%b %h expected v=1 %h", out_valid,
                     {ovf, cout, sum}, {1'b0, 1'b1, 16'h0000});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL carry_single: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] exp_sum;
`ifdef PIPE_ADDER_SAT_EN
        exp_sum = 16'h7FFF;
`else
        exp_sum = 16'h8000;
`endif
        @(negedge clk);
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b1, 1'b0, exp_sum}) begin
            n_fail++;
            $display("FAIL ovf_pos: got v=%b %h expected v=1 %h", out_valid,
                     {ovf, cout, sum}, {1'b1, 1'b0, exp_sum});
        end
    endtask

    task automatic test_subtract;
        logic [15:0] exp_b;
`ifdef PIPE_ADDER_SAT_EN
        exp_b = 16'h8000;
`else
        exp_b = 16'h7FFF;
`endif
        @(negedge clk);
        drive(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b0, 1'b0, 16'hFFFE}) begin
            n_fail++;
            $display("FAIL sub_borrow: got v=%b %h expected v=1 %h", out_valid,
                     {ovf, cout, sum}, {1'b0, 1'b0, 16'hFFFE});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b1, 1'b1, exp_b}) begin
            n_fail++;
            $display("FAIL sub_ovf: got v=%b %h expected v=1 %h", out_valid,
                     {ovf, cout, sum}, {1'b1, 1'b1, exp_b});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL sub_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] xa [4];
        logic [15:0] ya [4];
        logic        ca [4];
        logic        sa [4];
        logic [17:0] ea [4];
        xa = '{16'h1234, 16'h0F0F, 16'h00FF, 16'hFF00};
        ya = '{16'h1111, 16'h00FF, 16'h0001, 16'h0100};
        ca = '{1'b1, 1'b0, 1'b0, 1'b0};
        sa = '{1'b0, 1'b1, 1'b0, 1'b0};
        ea = '{{2'b00, 16'h2346}, {2'b01, 16'h0E10}, {2'b00, 16'h0100}, {2'b01, 16'h0000}};
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            if (t < 4) drive(1'b1, xa[t], ya[t], ca[t], sa[t]);
            else drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            #1;
            n_checks++;
            if (t >= 2 && t < 6) begin
                if (out_valid !== 1'b1 || {ovf, cout, sum} !== ea[t-2]) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got v=%b %h expected v=1 %h", t - 2,
                             out_valid, {ovf, cout, sum}, ea[t-2]);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle[%0d]: out_valid got %b expected 0", t, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] xa [3];
        logic [15:0] ya [3];
        logic [17:0] ea [3];
        int sent   = 0;
        int recv   = 0;
        int stalls = 0;
        xa = '{16'h0001, 16'h0010, 16'h0100};
        ya = '{16'h0002, 16'h0020, 16'h0200};
        ea = '{{2'b00, 16'h0003}, {2'b00, 16'h0030}, {2'b00, 16'h0300}};
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 7);
            if (sent < 3) drive(1'b1, xa[sent], ya[sent], 1'b0, 1'b0);
            else drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                n_checks++;
                if (in_ready !== 1'b0 || {ovf, cout, sum} !== ea[0]) begin
                    n_fail++;
                    $display("FAIL bp_stall: got in_ready=%b %h expected 0 %h", in_ready,
                             {ovf, cout, sum}, ea[0]);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (recv >= 3 || {ovf, cout, sum} !== ea[(recv < 3) ? recv : 0]) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got %h expected %h", recv,
                             {ovf, cout, sum}, ea[(recv < 3) ? recv : 0]);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        n_checks++;
        if (recv !== 3 || stalls !== 5) begin
            n_fail++;
            $display("FAIL bp_count: got recv=%0d stalls=%0d expected 3/5", recv, stalls);
        end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, 16'h1000, 16'h0234, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h2000, 16'h0345, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || sum !== 16'h1234) begin
            n_fail++;
            $display("FAIL mid_inflight: got v=%b %h expected v=1 1234", out_valid, sum);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {ovf, cout, sum} !== 18'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b rdy=%b %h expected 0/1/0", out_valid, in_ready,
                     {ovf, cout, sum});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale[%0d]: out_valid got %b expected 0", i, out_valid);
            end
            @(negedge clk);
        end
        drive(1'b1, 16'h0042, 16'h0008, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_lat1: out_valid got %b expected 0", out_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== {2'b00, 16'h004A}) begin
            n_fail++;
            $display("FAIL mid_next: got v=%b %h expected v=1 %h", out_valid,
                     {ovf, cout, sum}, {2'b00, 16'h004A});
        end
    endtask

    task automatic test_random;
        logic [17:0] q [$];
        logic [17:0] e;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic pend = 1'b0;
        while ((sent < 1000 || recv < 1000) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                    pend = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            n_checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_fail++;
                $display("FAIL rand_ready: got %b expected %b", in_ready,
                         !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got %h expected no result", {ovf, cout, sum});
                end else begin
                    e = q.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        n_fail++;
                        $display("FAIL rand_data[%0d]: got %h expected %h", recv,
                                 {ovf, cout, sum}, e);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(x, y, cin, sub));
                sent++;
                pend = 1'b0;
            end
        end
        n_checks++;
        if (recv !== 1000 || q.size() !== 0 || cyc >= 20000) begin
            n_fail++;
            $display("FAIL rand_count: got recv=%0d left=%0d cycles=%0d expected 1000/0/<20000",
                     recv, q.size(), cyc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
